// File: rtl/isb_pkg.sv
// rtl/isb_pkg.sv - shared types and default widths for the writeback stage
package isb_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic              wen;
        logic [REG_W-1:0]  rt;
        logic [DATA_W-1:0] res;
        logic              halt;
    } wb_entry_t;

endpackage

// File: rtl/wb_skid_fifo.sv
// rtl/wb_skid_fifo.sv - two-entry in-order buffer between memory and writeback
module wb_skid_fifo
    import isb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic       i_clear,
    input  wb_entry_t  i_data,
    output logic [1:0] o_count,
    output wb_entry_t  o_head
);

    wb_entry_t  r_mem [2];
    logic       r_rd;
    logic       r_wr;
    logic [1:0] r_count;

    // Callers only push when count<2 and pop when count>0; clear wins over both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_count <= 2'd0;
        end else if (i_clear) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (i_push) r_wr <= ~r_wr;
            if (i_pop)  r_rd <= ~r_rd;
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_clear) r_mem[r_wr] <= i_data;
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd];

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: buffered retirement, register write port, halt drain
module wb_stage
    import isb_pkg::*;
#(
    parameter int DATA_W     = isb_pkg::DATA_W,
    parameter int REG_W      = isb_pkg::REG_W,
    parameter int HALT_DRAIN = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              M_v,
    output logic              M_ready,
    input  logic              M_wen,
    input  logic [REG_W-1:0]  M_rt,
    input  logic [DATA_W-1:0] M_res,
    input  logic              M_halt,
    input  logic              flush,
    input  logic              rf_busy,
    output logic              W_v,
    output logic              W_wen,
    output logic [REG_W-1:0]  W_rt,
    output logic [DATA_W-1:0] W_data,
    output logic              isHalt
);

    wb_state_t  r_state;
    wb_state_t  w_state_nxt;
    logic [3:0] r_drain_cnt;

    logic       w_run;
    logic       w_flush;
    logic       w_push;
    logic       w_retire;
    logic       w_halt_retire;
    logic [1:0] w_count;
    wb_entry_t  w_head;
    wb_entry_t  w_in;

    assign w_run         = (r_state == RUN);
    assign w_flush       = w_run && flush;
    assign w_push        = M_v && M_ready;
    assign w_retire      = (w_count != 2'd0) && w_run && !flush && (!w_head.wen || !rf_busy);
    assign w_halt_retire = w_retire && w_head.halt;

    // Entry fields take the package widths, which are the parameter defaults.
    assign w_in = '{wen: M_wen, rt: M_rt, res: M_res, halt: M_halt};

    // A retiring halt also clears, dropping anything queued or arriving behind it.
    wb_skid_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_retire),
        .i_clear (w_flush || w_halt_retire),
        .i_data  (w_in),
        .o_count (w_count),
        .o_head  (w_head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_drain_cnt <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_halt_retire)
                r_drain_cnt <= 4'(HALT_DRAIN - 1);
            else if (r_state == DRAIN && r_drain_cnt != 4'd0)
                r_drain_cnt <= r_drain_cnt - 4'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (w_halt_retire) w_state_nxt = DRAIN;
            DRAIN:   if (r_drain_cnt == 4'd0) w_state_nxt = HALTED;
            HALTED:  w_state_nxt = HALTED;
            default: w_state_nxt = RUN;
        endcase
    end

    always_comb begin
        M_ready = (w_count < 2'd2) && w_run && !flush;
        isHalt  = (r_state == HALTED);
    end

    // Write enable drops whenever nothing retires so the port never rewrites stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            W_v    <= 1'b0;
            W_wen  <= 1'b0;
            W_rt   <= '0;
            W_data <= '0;
        end else begin
            W_v   <= w_retire;
            W_wen <= w_retire && w_head.wen && (w_head.rt != '0);
            if (w_retire) begin
                W_rt   <= w_head.rt;
                W_data <= w_head.res;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage
module tb_wb_stage;

    localparam int HD = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        M_v = 1'b0, M_wen = 1'b0, M_halt = 1'b0, flush = 1'b0, rf_busy = 1'b0;
    logic [3:0]  M_rt = '0;
    logic [15:0] M_res = '0;
    logic        M_ready, W_v, W_wen, isHalt;
    logic [3:0]  W_rt;
    logic [15:0] W_data;

    always #5 clk = ~clk;

    wb_stage #(.DATA_W(16), .REG_W(4), .HALT_DRAIN(HD)) dut (
        .clk(clk), .rst_n(rst_n), .M_v(M_v), .M_ready(M_ready), .M_wen(M_wen),
        .M_rt(M_rt), .M_res(M_res), .M_halt(M_halt), .flush(flush), .rf_busy(rf_busy),
        .W_v(W_v), .W_wen(W_wen), .W_rt(W_rt), .W_data(W_data), .isHalt(isHalt)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    typedef struct {
        bit        wen;
        bit [3:0]  rt;
        bit [15:0] res;
        bit        halt;
    } mentry_t;

    mentry_t q[$];
    bit      m_run = 1'b1;
    int      m_ticks = 0;

    logic       last_ready, last_wv, last_wen;
    logic [3:0] last_rt;
    int         rets[$];

    task automatic model_reset();
        q.delete();
        m_run = 1'b1;
        m_ticks = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; M_v = 1'b0; flush = 1'b0; rf_busy = 1'b0; M_halt = 1'b0;
        #1;
        chk("rst_W_v", W_v, 0);
        chk("rst_W_wen", W_wen, 0);
        chk("rst_W_rt", W_rt, 0);
        chk("rst_W_data", W_data, 0);
        chk("rst_isHalt", isHalt, 0);
        chk("rst_M_ready", M_ready, 1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One cycle: drive at negedge, check ready, advance the model, check outputs at next negedge.
    task automatic step(input bit mv, input bit wen, input bit [3:0] rt, input bit [15:0] res,
                        input bit halt, input bit fl, input bit busy);
        bit      exp_ready, ev, ewen;
        bit [3:0] ert;
        bit [15:0] edata;
        mentry_t h;
        M_v = mv; M_wen = wen; M_rt = rt; M_res = res; M_halt = halt; flush = fl; rf_busy = busy;
        #1;
        exp_ready = (q.size() < 2) && m_run && !fl;
        last_ready = M_ready;
        chk("M_ready", M_ready, exp_ready);
        ev = 0; ewen = 0; ert = 0; edata = 0;
        if (m_run) begin
            if (fl) q.delete();
            else begin
                if (q.size() > 0 && (!q[0].wen || !busy)) begin
                    h = q.pop_front();
                    ev = 1; ewen = h.wen && (h.rt != 0); ert = h.rt; edata = h.res;
                end
                if (mv && exp_ready) q.push_back('{wen, rt, res, halt});
                if (ev && h.halt) begin
                    q.delete();
                    m_run = 1'b0;
                    m_ticks = HD;
                end
            end
        end else if (m_ticks > 0) m_ticks--;
        @(posedge clk);
        @(negedge clk);
        last_wv = W_v; last_wen = W_wen; last_rt = W_rt;
        if (W_v) rets.push_back(int'(W_rt));
        chk("W_v", W_v, ev);
        if (ev) begin
            chk("W_wen", W_wen, ewen);
            chk("W_rt", W_rt, ert);
            chk("W_data", W_data, edata);
        end
        chk("isHalt", isHalt, !m_run && m_ticks == 0);
    endtask

    typedef struct {
        bit mv, wen; bit [3:0] rt; bit [15:0] res; bit halt, fl, busy;
        bit e_ready, e_wv, e_wen; bit [3:0] e_rt; bit [15:0] e_data;
    } vec_t;

    vec_t vecs[9];
    int   wv_cnt;

    initial begin
        vecs[0] = '{1,1,4'd3,16'h0010,0,0,0, 1,0,0,4'd0,16'h0000};
        vecs[1] = '{1,1,4'd4,16'h0011,0,0,0, 1,1,1,4'd3,16'h0010};
        vecs[2] = '{1,1,4'd5,16'h0012,0,0,0, 1,1,1,4'd4,16'h0011};
        vecs[3] = '{1,1,4'd6,16'h0013,0,0,0, 1,1,1,4'd5,16'h0012};
        vecs[4] = '{0,0,4'd0,16'h0000,0,0,0, 1,1,1,4'd6,16'h0013};
        vecs[5] = '{0,0,4'd0,16'h0000,0,0,0, 1,0,0,4'd0,16'h0000};
        vecs[6] = '{1,1,4'd0,16'hFFFF,0,0,0, 1,0,0,4'd0,16'h0000};
        vecs[7] = '{0,0,4'd0,16'h0000,0,0,0, 1,1,0,4'd0,16'hFFFF};
        vecs[8] = '{0,0,4'd0,16'h0000,0,0,0, 1,0,0,4'd0,16'h0000};

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 9; i++) begin
            step(vecs[i].mv, vecs[i].wen, vecs[i].rt, vecs[i].res, vecs[i].halt, vecs[i].fl, vecs[i].busy);
            chk($sformatf("vec%0d_ready", i), last_ready, vecs[i].e_ready);
            chk($sformatf("vec%0d_wv", i), last_wv, vecs[i].e_wv);
            if (vecs[i].e_wv) begin
                chk($sformatf("vec%0d_wen", i), last_wen, vecs[i].e_wen);
                chk($sformatf("vec%0d_rt", i), last_rt, vecs[i].e_rt);
                chk($sformatf("vec%0d_data", i), W_data, vecs[i].e_data);
            end
        end

        // rf_busy holds writes; third offer blocked while full
        do_reset();
        rets.delete();
        wv_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 4'(7 + (i > 2 ? 2 : i)), 16'h0070, 0, 0, 1);
            wv_cnt += int'(last_wv);
            if (i >= 2) chk("busy_full_ready", last_ready, 0);
        end
        chk("busy_no_wv", wv_cnt, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
        chk("busy_ret_cnt", rets.size(), 2);
        if (rets.size() == 2) begin
            chk("busy_ret0", rets[0], 7);
            chk("busy_ret1", rets[1], 8);
        end

        // halt then add: add discarded, isHalt two cycles after halt pulse
        do_reset();
        step(1, 0, 0, 16'h0000, 1, 0, 0);
        step(1, 1, 5, 16'h0055, 0, 0, 0);
        chk("halt_wv", last_wv, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("halt_wv_add", last_wv, 0);
        chk("halt_early", isHalt, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("halt_set", isHalt, 1);
        step(1, 1, 5, 16'h0055, 0, 1, 0);
        chk("halted_ready", last_ready, 0);
        chk("halted_wv", last_wv, 0);

        // flush with two buffered entries
        do_reset();
        step(1, 1, 1, 16'h0011, 0, 0, 1);
        step(1, 1, 2, 16'h0022, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("flush_wv", last_wv, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("flush_ready", last_ready, 1);
        chk("flush_wv_after", last_wv, 0);

        // reset during drain
        do_reset();
        step(1, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("drain_halt_wv", last_wv, 1);
        do_reset();
        step(1, 1, 4, 16'h0044, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_wv", last_wv, 1);
        chk("post_rst_rt", last_rt, 4);
        chk("post_rst_wen", last_wen, 1);

        // randomized traffic against the queue model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ((!m_run && m_ticks == 0 && $urandom_range(3) == 0) || $urandom_range(299) == 0)
                do_reset();
            step($urandom_range(3) != 0, 1'($urandom), 4'($urandom), 16'($urandom),
                 $urandom_range(24) == 0, $urandom_range(29) == 0, $urandom_range(2) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter DATA_W, default 16, register write-data width.
REQ-002 Parameter REG_W, default 4, register index width (16 architectural registers).
REQ-003 Parameter HALT_DRAIN, default 2, cycles between halt retirement and isHalt assertion (1..15).
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 M_v  input  1  memory stage offers one completed instruction.
REQ-007 M_ready  output  1  wb_stage accepts the offer this cycle.
REQ-008 M_wen  input  1  instruction writes a register.
REQ-009 M_rt  input  REG_W  destination register index.
REQ-010 M_res  input  DATA_W  result value.
REQ-011 M_halt  input  1  instruction is a halt.
REQ-012 flush  input  1  squash all buffered, unretired instructions.
REQ-013 rf_busy  input  1  register-file write port unavailable this cycle.
REQ-014 W_v  output  1  one-cycle pulse per retired instruction; consumed by the cycle/instruction counter.
REQ-015 W_wen, W_rt, W_data  output  1/REG_W/DATA_W  register-file write port.
REQ-016 isHalt  output  1  machine halted; held high until reset.

Function
REQ-017 Transfer occurs on posedge when M_v && M_ready; the entry {wen, rt, res, halt} is appended to a 2-entry in-order buffer.
REQ-018 M_ready = (registered count < 2) && state==RUN && !flush; no same-cycle pass-through when full, even if the head retires.
REQ-019 Head is retire-eligible when count>0, state==RUN, !flush, and (!head.wen || !rf_busy).
REQ-020 On an eligible edge the head pops and W_v/W_wen/W_rt/W_data load from it; W_v is high for exactly that following cycle, else 0.
REQ-021 Minimum latency: accepted at edge k, W_v high in the cycle after edge k+1 (empty buffer, rf_busy=0).
REQ-022 W_wen is forced 0 when rt==0; W_v still pulses.
REQ-023 At most one retirement per cycle; a push and a pop on the same edge leave count unchanged.
REQ-024 States RUN, DRAIN, HALTED. RUN->DRAIN when a halt entry retires (W_v=1, W_wen=0); drain counter loads HALT_DRAIN-1.
REQ-025 DRAIN: counter decrements each cycle; at 0 -> HALTED. HALTED: isHalt=1, terminal until rst_n low.
REQ-026 On RUN->DRAIN all entries behind the halt are discarded without W_v; M_ready=0 in DRAIN/HALTED.
REQ-027 flush in RUN empties the buffer on that edge, no retirement that cycle (flush beats retire and accept); flush ignored in DRAIN/HALTED.
REQ-028 rf_busy stalls only write entries; a non-writing head retires regardless.

Reset
REQ-029 rst_n low clears immediately: count=0, state=RUN, W_v=0, W_wen=0, W_rt=0, W_data=0, isHalt=0, drain counter=0; M_ready reflects reset state.
REQ-030 Reset asserted mid-drain or with a full buffer discards all entries; no W_v after release until a new transfer.

Structure
REQ-031 Shared package isb_pkg holds DATA_W/REG_W defaults, wb_state_t enum {RUN, DRAIN, HALTED} and wb_entry_t struct {wen, rt, res, halt}.
REQ-032 Buffer is sub-module wb_skid_fifo (2 entries, push/pop/clear, count, head); FSM and output registers stay in wb_stage.

Verification
REQ-033 Back-to-back M_v with wen=1, rt=3..6, res=0x0010..0x0013, rf_busy=0 -> four consecutive W_v pulses, W_rt 3..6, W_data 0x0010..0x0013, M_ready constantly 1.
REQ-034 rf_busy=1 for 5 cycles with 3 offered writes -> two accepted, M_ready=0 while full, no W_v; after rf_busy drops, retire in order.
REQ-035 Write to rt=0, res=0xFFFF -> W_v=1, W_wen=0.
REQ-036 Halt followed by one queued add, HALT_DRAIN=2 -> W_v for halt only, add discarded, isHalt=1 two cycles after halt W_v, M_ready=0 thereafter.
REQ-037 flush with 2 buffered entries and rf_busy=0 -> no W_v that edge, count=0, M_ready=1 next cycle.
REQ-038 rst_n low during DRAIN -> isHalt stays 0, state RUN after release, first new instruction retires normally.
